// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: defaults, FSM states and queue entry layout.
package fetch_buffer_pkg;

    localparam int          FB_DEPTH    = 4;
    localparam logic [31:0] FB_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue of {pc, instr} with read/write pointers, occupancy count and flush.
module fetch_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output logic          not_empty,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign count     = cnt_q;
    assign not_empty = (cnt_q != '0);
    assign head      = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch unit: single-outstanding memory requester feeding an in-order instruction queue,
// with redirect flush and discard of in-flight data.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = FB_DEPTH,
    parameter logic [31:0] RESET_PC = FB_RESET_PC
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic         instr_valid,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    input  logic         instr_ready,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output fetch_state_t state_dbg
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q;
    logic [CW-1:0] occ;
    logic [CW-1:0] occ_after_ack;
    logic          issue_now, keep_data, push, pop, credit_after_ack;
    fetch_entry_t  head;

    // Handshakes: memory side -- imem_req/imem_addr hold until the edge that samples imem_ack=1,
    // which completes the request; decoder side -- the head transfers on an edge with
    // instr_valid && instr_ready, unless redirect is high, which flushes instead.
    assign pop       = instr_valid && instr_ready && !redirect;
    assign issue_now = reset && (state_q == IDLE) && !redirect && (occ < CW'(DEPTH));
    assign keep_data = issue_now || (state_q == REQ);
    assign push      = keep_data && imem_ack && !redirect;

    // Occupancy seen by the next request if the current one completes now; never overflows
    // because a kept request only exists while occ < DEPTH.
    assign occ_after_ack    = occ + CW'(1) - CW'(pop);
    assign credit_after_ack = (occ_after_ack < CW'(DEPTH));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect)  fetch_pc_d = word_align(redirect_pc);
        else if (push) fetch_pc_d = fetch_pc_q + 32'd4;

        case (state_q)
            IDLE: begin
                if (issue_now) state_d = (imem_ack && !credit_after_ack) ? IDLE : REQ;
            end
            REQ: begin
                if (redirect)      state_d = imem_ack ? IDLE : DRAIN;
                else if (imem_ack) state_d = credit_after_ack ? REQ : IDLE;
            end
            DRAIN: begin
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= word_align(RESET_PC);
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (state_d == REQ) req_addr_q <= fetch_pc_d;
        end
    end

    // In DRAIN fetch_pc already holds the redirect target, so the bus shows the captured address.
    assign imem_req  = issue_now || (state_q != IDLE);
    assign imem_addr = (state_q != IDLE) ? req_addr_q : (issue_now ? fetch_pc_q : 32'h0);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data ('{pc: fetch_pc_q, instr: imem_rdata}),
        .pop       (pop),
        .not_empty (instr_valid),
        .head      (head),
        .count     (occ)
    );

    assign instr     = head.instr;
    assign instr_pc  = head.pc;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized and directed bench for fetch_buffer: memory responder, stream reference model and monitor.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack = 1'b0;
    logic [31:0]  imem_rdata = 32'h0;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;
    logic         instr_ready = 1'b0;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = 32'h0;
    fetch_state_t state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int lat      = 1;
    int wait_cnt = 0;
    int rel_cyc  = 0;
    int hs_total = 0;
    bit force_late_ack = 1'b0;
    bit prev_pending   = 1'b0;
    bit prev_redirect  = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] mon_exp;

    logic [31:0] exp_q[$];
    logic [31:0] req_log_q[$];
    logic [31:0] ack_log_q[$];
    logic [31:0] hs_pc_q[$];
    int          hs_cyc_q[$];

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    // Reference model: the decoder must see the word-aligned start address and then consecutive words.
    function automatic void restart_stream(input logic [31:0] pc);
        logic [31:0] base;
        base = pc & 32'hFFFF_FFFC;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(base + 32'(4 * i));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        redirect = 1'b0;
        repeat (2) tick();
        restart_stream(RST_PC);
        req_log_q.delete();
        ack_log_q.delete();
        hs_pc_q.delete();
        hs_cyc_q.delete();
        reset   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        restart_stream(pc);
        tick();
        redirect = 1'b0;
    endtask

    // ---------------- memory responder ----------------
    always @(negedge clk) begin
        if (!reset) begin
            imem_ack     = force_late_ack;
            imem_rdata   = 32'hBAD0_BAD0;
            wait_cnt     = 0;
            prev_pending = 1'b0;
        end else begin
            if (prev_pending) begin
                check("req_held", 32'(imem_req), 32'd1);
                check("addr_stable", imem_addr, prev_addr);
            end
            if (imem_req) begin
                if (wait_cnt == 0) req_log_q.push_back(imem_addr);
                if (wait_cnt + 1 >= lat) begin
                    imem_ack     = 1'b1;
                    imem_rdata   = mem_word(imem_addr);
                    ack_log_q.push_back(imem_addr);
                    wait_cnt     = 0;
                    prev_pending = 1'b0;
                end else begin
                    imem_ack     = 1'b0;
                    wait_cnt++;
                    prev_pending = 1'b1;
                    prev_addr    = imem_addr;
                end
            end else begin
                imem_ack     = 1'b0;
                wait_cnt     = 0;
                prev_pending = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            if (prev_redirect) check("valid_after_redirect", 32'(instr_valid), 32'd0);
            if (instr_valid && instr_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    check("stream_expectation", instr_pc, 32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    exp_q.push_back(exp_q[$] + 32'd4);
                    check("instr_pc", instr_pc, mon_exp);
                    check("instr", instr, mem_word(mon_exp));
                end
                hs_pc_q.push_back(instr_pc);
                hs_cyc_q.push_back(cyc);
                hs_total++;
            end
        end
        prev_redirect = reset && redirect;
    end

    // ---------------- stimulus ----------------
    initial begin
        int hs_before;

        // Reset release, latency 1, decoder always ready.
        lat = 1;
        instr_ready = 1'b1;
        do_reset();
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RST_PC);
        repeat (8) tick();
        check("p1_hs_count", 32'(hs_cyc_q.size() >= 4), 32'd1);
        if (hs_cyc_q.size() >= 4) begin
            check("p1_latency", 32'(hs_cyc_q[0]), 32'(rel_cyc + 1));
            check("p1_one_per_cycle", 32'(hs_cyc_q[3] - hs_cyc_q[0]), 32'd3);
            for (int i = 0; i < 4; i++) check("p1_order", hs_pc_q[i], RST_PC + 32'(4 * i));
        end

        // Credit limit with the decoder stalled.
        instr_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        check("p2_nreq", 32'(ack_log_q.size()), 32'd4);
        for (int i = 0; i < ack_log_q.size() && i < 4; i++)
            check("p2_req_addr", ack_log_q[i], 32'(4 * i));
        check("p2_req_low", 32'(imem_req), 32'd0);
        check("p2_full_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        repeat (5) tick();
        check("p2_nreq_after_pop", 32'(ack_log_q.size()), 32'd5);
        if (ack_log_q.size() >= 5) check("p2_refill_addr", ack_log_q[4], 32'h10);
        check("p2_req_low_again", 32'(imem_req), 32'd0);
        check("p2_pops", 32'(hs_pc_q.size()), 32'd1);

        // Redirect while a slow request is outstanding.
        lat = 3;
        instr_ready = 1'b1;
        do_reset();
        tick();
        check("p3_mid_req", 32'(imem_req), 32'd1);
        pulse_redirect(32'h200);
        req_log_q.delete();
        hs_pc_q.delete();
        repeat (20) tick();
        check("p3_next_addr", (req_log_q.size() > 0) ? req_log_q[0] : 32'hDEAD_DEAD, 32'h200);
        check("p3_first_pc", (hs_pc_q.size() > 0) ? hs_pc_q[0] : 32'hDEAD_DEAD, 32'h200);

        // Unaligned redirect target.
        lat = 1;
        tick();
        pulse_redirect(32'h103);
        req_log_q.delete();
        hs_pc_q.delete();
        repeat (10) tick();
        check("p4_next_addr", (req_log_q.size() > 0) ? req_log_q[0] : 32'hDEAD_DEAD, 32'h100);
        check("p4_first_pc", (hs_pc_q.size() > 0) ? hs_pc_q[0] : 32'hDEAD_DEAD, 32'h100);

        // Redirect in the same cycle the decoder would accept the head.
        instr_ready = 1'b0;
        repeat (6) tick();
        check("p5_valid_before", 32'(instr_valid), 32'd1);
        hs_pc_q.delete();
        instr_ready = 1'b1;
        pulse_redirect(32'h400);
        check("p5_valid_after", 32'(instr_valid), 32'd0);
        repeat (6) tick();
        check("p5_refetch_pc", (hs_pc_q.size() > 0) ? hs_pc_q[0] : 32'hDEAD_DEAD, 32'h400);

        // Asynchronous reset in the middle of a request with three entries queued.
        lat = 3;
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 40 && ack_log_q.size() < 3; i++) tick();
        check("p6_three_acks", 32'(ack_log_q.size()), 32'd3);
        tick();
        check("p6_req_before", 32'(imem_req), 32'd1);
        check("p6_valid_before", 32'(instr_valid), 32'd1);
        #1;
        reset = 1'b0;
        force_late_ack = 1'b1;
        #1;
        check("p6_rst_req", 32'(imem_req), 32'd0);
        check("p6_rst_addr", imem_addr, 32'd0);
        check("p6_rst_valid", 32'(instr_valid), 32'd0);
        check("p6_rst_instr", instr, 32'd0);
        check("p6_rst_pc", instr_pc, 32'd0);
        check("p6_rst_state", 32'(state_dbg), 32'(IDLE));
        repeat (2) tick();
        check("p6_late_ack_valid", 32'(instr_valid), 32'd0);
        check("p6_late_ack_req", 32'(imem_req), 32'd0);
        force_late_ack = 1'b0;
        lat = 1;
        instr_ready = 1'b1;
        do_reset();
        repeat (6) tick();
        check("p6_restart_addr", (req_log_q.size() > 0) ? req_log_q[0] : 32'hDEAD_DEAD, RST_PC);
        check("p6_restart_pc", (hs_pc_q.size() > 0) ? hs_pc_q[0] : 32'hDEAD_DEAD, RST_PC);

        // Address wrap, then randomized traffic against the stream model.
        pulse_redirect(32'hFFFF_FFF8);
        repeat (10) tick();
        hs_before = hs_total;
        for (int i = 0; i < 1500; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 19) == 0) pulse_redirect($urandom());
            else tick();
        end
        check("rand_progress", 32'(hs_total - hs_before > 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
